// File: rtl/sfx_sequencer_if.sv
// ---------------------------------------------------------------------------
// sfx_sequencer_if
//
// Purpose: groups the request/time-base inputs and the playback status
// outputs of the sound-effect sequencer into one bundle.
//
// Signals:
//   req[2:0]       one-cycle effect request pulses (bit2 highest priority)
//   dur_tick       one-cycle slow time-base pulse for note durations
//   tone_en        one-cycle pulse stepping the sine-table address counter
//   play_en        high while a note sounds
//   busy           high whenever the sequencer is not idle
//   effect_id[1:0] effect currently (or last) playing
//   note_idx[1:0]  note index within the effect
//
// Modports:
//   master - the requester side (drives req/dur_tick, observes status)
//   slave  - the sequencer side
// ---------------------------------------------------------------------------
interface sfx_sequencer_if;
    logic [2:0] req;
    logic       dur_tick;
    logic       tone_en;
    logic       play_en;
    logic       busy;
    logic [1:0] effect_id;
    logic [1:0] note_idx;

    modport master (
        output req, dur_tick,
        input  tone_en, play_en, busy, effect_id, note_idx
    );

    modport slave (
        input  req, dur_tick,
        output tone_en, play_en, busy, effect_id, note_idx
    );
endinterface

// File: rtl/sfx_sequencer.sv
// ---------------------------------------------------------------------------
// sfx_sequencer
//
// Purpose: plays short sound effects made of fixed divider/duration notes.
// A request starts an effect; each note loads a pitch divider and a duration
// (in dur_tick units). While a note plays, tone_en pulses once every div
// cycles to step an external sine-table address counter. A higher-priority
// request preempts the running effect; equal/lower ones are dropped.
//
// Ports:
//   clk     system clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     sfx_sequencer_if.slave (req, dur_tick in; tone_en, play_en,
//           busy, effect_id, note_idx out)
// ---------------------------------------------------------------------------
module sfx_sequencer #(
    parameter int DIV_WIDTH = 8,
    parameter int DUR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetN,
    sfx_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t               state_q;
    logic [1:0]           effect_id_q;
    logic [1:0]           note_idx_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DUR_WIDTH-1:0] dur_cnt_q;

    logic [1:0]           req_hi;
    logic                 req_any;
    logic                 preempt;
    logic                 last_note;
    logic [DIV_WIDTH-1:0] div_reload;

    // Note table: pitch divider per (effect, note).
    function automatic logic [DIV_WIDTH-1:0] note_div(input logic [1:0] eff,
                                                      input logic [1:0] idx);
        logic [DIV_WIDTH-1:0] d;
        case ({eff, idx})
            4'b00_00: d = DIV_WIDTH'(40);
            4'b00_01: d = DIV_WIDTH'(30);
            4'b00_10: d = DIV_WIDTH'(20);
            4'b01_00: d = DIV_WIDTH'(80);
            4'b01_01: d = DIV_WIDTH'(100);
            4'b01_10: d = DIV_WIDTH'(120);
            4'b01_11: d = DIV_WIDTH'(140);
            4'b10_00: d = DIV_WIDTH'(60);
            4'b10_01: d = DIV_WIDTH'(80);
            4'b10_10: d = DIV_WIDTH'(100);
            4'b10_11: d = DIV_WIDTH'(160);
            default:  d = DIV_WIDTH'(1);
        endcase
        return d;
    endfunction

    // Note table: duration per (effect, note), never zero.
    function automatic logic [DUR_WIDTH-1:0] note_dur(input logic [1:0] eff,
                                                      input logic [1:0] idx);
        logic [DUR_WIDTH-1:0] d;
        case (eff)
            2'd0:    d = DUR_WIDTH'(2);
            2'd1:    d = DUR_WIDTH'(3);
            2'd2:    d = (idx == 2'd3) ? DUR_WIDTH'(16) : DUR_WIDTH'(8);
            default: d = DUR_WIDTH'(1);
        endcase
        return d;
    endfunction

    // Highest set request bit wins.
    always_comb begin
        req_hi = 2'd0;
        if (bus.req[1]) req_hi = 2'd1;
        if (bus.req[2]) req_hi = 2'd2;
    end

    assign req_any    = |bus.req;
    // Only a strictly higher effect may interrupt the one that is playing.
    assign preempt    = req_any && (req_hi > effect_id_q);
    assign last_note  = (effect_id_q == 2'd0) ? (note_idx_q == 2'd2)
                                              : (note_idx_q == 2'd3);
    // Counter reloads with div-1 so the pulse period is exactly div cycles.
    assign div_reload = note_div(effect_id_q, note_idx_q) - DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            effect_id_q <= 2'd0;
            note_idx_q  <= 2'd0;
            div_cnt_q   <= '0;
            dur_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        state_q     <= LOAD;
                        effect_id_q <= req_hi;
                        note_idx_q  <= 2'd0;
                    end
                end

                LOAD: begin
                    if (preempt) begin
                        effect_id_q <= req_hi;
                        note_idx_q  <= 2'd0;
                    end else begin
                        div_cnt_q <= div_reload;
                        dur_cnt_q <= note_dur(effect_id_q, note_idx_q);
                        state_q   <= PLAY;
                    end
                end

                PLAY: begin
                    if (div_cnt_q == '0) begin
                        div_cnt_q <= div_reload;
                    end else begin
                        div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
                    end

                    // Preemption outranks a note advance/finish in the same cycle.
                    if (preempt) begin
                        state_q     <= LOAD;
                        effect_id_q <= req_hi;
                        note_idx_q  <= 2'd0;
                    end else if (bus.dur_tick) begin
                        if (dur_cnt_q == DUR_WIDTH'(1)) begin
                            if (last_note) begin
                                state_q <= IDLE;
                            end else begin
                                note_idx_q <= note_idx_q + 2'd1;
                                state_q    <= LOAD;
                            end
                        end else begin
                            dur_cnt_q <= dur_cnt_q - DUR_WIDTH'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Status outputs are pure decodes of registers, so reset clears them
    // immediately and tone_en is still emitted in an advance/finish cycle.
    assign bus.tone_en   = (state_q == PLAY) && (div_cnt_q == '0);
    assign bus.play_en   = (state_q == PLAY);
    assign bus.busy      = (state_q != IDLE);
    assign bus.effect_id = effect_id_q;
    assign bus.note_idx  = note_idx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sfx_sequencer
//
// Directed bench for sfx_sequencer. Expected notes are queued when an
// effect is requested and compared as each note starts playing; every
// tone_en pulse is checked against the expected divider of that note.
// ---------------------------------------------------------------------------
module tb_sfx_sequencer;

    logic clk;
    logic resetN;

    sfx_sequencer_if bus ();

    sfx_sequencer #(
        .DIV_WIDTH(8),
        .DUR_WIDTH(8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int tick_period = 50;
    bit tick_on = 1'b0;

    int exp_q[$];
    int cur_div = 0;
    int gap = 0;
    int note_ticks = 0;
    int total_ticks = 0;
    int last_tick_cyc = -1;
    int fall_cyc = -1;
    int notes_played = 0;
    int pulses = 0;
    int first_gap = -1;
    bit play_prev = 1'b0;
    bit busy_prev = 1'b0;

    function automatic int tb_div(input int e, input int n);
        case (e * 4 + n)
            0: return 40;   1: return 30;   2: return 20;
            4: return 80;   5: return 100;  6: return 120;  7: return 140;
            8: return 60;   9: return 80;   10: return 100; 11: return 160;
            default: return -1;
        endcase
    endfunction

    function automatic int tb_last(input int e);
        return (e == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_effect(input int e);
        for (int n = 0; n <= tb_last(e); n++) exp_q.push_back(e * 4 + n);
    endtask

    task automatic reset_counts();
        total_ticks   = 0;
        notes_played  = 0;
        pulses        = 0;
        fall_cyc      = -1;
        last_tick_cyc = -1;
        first_gap     = -1;
    endtask

    // One clock cycle: drive inputs at cycle start, observe at the falling edge.
    task automatic step(input logic [2:0] r, input bit force_tick);
        int e;
        bus.req      = r;
        bus.dur_tick = force_tick || (tick_on && (cyc % tick_period == 0));
        @(negedge clk);
        if (bus.play_en) begin
            if (!play_prev) begin
                chk("note_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("note_effect", 32'(bus.effect_id), e / 4);
                    chk("note_index", 32'(bus.note_idx), e % 4);
                    cur_div = tb_div(e / 4, e % 4);
                    $display("note start cycle %0d effect %0d note %0d div %0d",
                             cyc, e / 4, e % 4, cur_div);
                end
                gap = 1;
                note_ticks = 0;
                notes_played++;
            end else begin
                gap++;
            end
            if (bus.dur_tick) begin
                note_ticks++;
                total_ticks++;
                last_tick_cyc = cyc;
            end
        end
        if (bus.tone_en) begin
            chk("tone_only_in_play", 32'(bus.play_en), 1);
            chk("tone_period", gap, cur_div);
            if (pulses == 0) first_gap = gap;
            pulses++;
            gap = 0;
        end
        if (busy_prev && !bus.busy) fall_cyc = cyc;
        play_prev = bus.play_en;
        busy_prev = bus.busy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Request an effect from idle and check the n+1 / n+2 latency.
    task automatic start_fx(input logic [2:0] r, input int e);
        chk("idle_before_req", 32'(bus.busy), 0);
        push_effect(e);
        step(r, 1'b0);
        chk("busy_at_n1", 32'(bus.busy), 1);
        chk("load_play_en_0", 32'(bus.play_en), 0);
        chk("start_effect", 32'(bus.effect_id), e);
        chk("start_note0", 32'(bus.note_idx), 0);
        step(3'b000, 1'b0);
        chk("play_en_at_n2", 32'(bus.play_en), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy && k < 5000) begin
            step(3'b000, 1'b0);
            k++;
        end
        chk(tag, 32'(bus.busy), 0);
        step(3'b000, 1'b0);
    endtask

    task automatic wait_note(input int n, input string tag);
        int k;
        k = 0;
        while (!(bus.play_en && bus.note_idx == 2'(n)) && k < 5000) begin
            step(3'b000, 1'b0);
            k++;
        end
        chk(tag, 32'(bus.play_en && bus.note_idx == 2'(n)), 1);
    endtask

    initial begin
        int k;
        int pulses_before;

        resetN       = 1'b0;
        bus.req      = 3'b000;
        bus.dur_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_tone_en", 32'(bus.tone_en), 0);
        chk("rst_play_en", 32'(bus.play_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_effect_id", 32'(bus.effect_id), 0);
        chk("rst_note_idx", 32'(bus.note_idx), 0);

        // Effect 0 accepted on the first edge after release, ticks every 50.
        resetN      = 1'b1;
        tick_on     = 1'b1;
        tick_period = 50;
        reset_counts();
        start_fx(3'b001, 0);
        wait_idle("e0_done");
        chk("e0_counted_ticks", total_ticks, 6);
        chk("e0_busy_fall", fall_cyc, last_tick_cyc + 1);
        chk("e0_notes", notes_played, 3);
        chk("e0_first_period", first_gap, 40);
        chk("e0_pulses_seen", 32'(pulses >= 3), 1);
        chk("e0_queue_empty", exp_q.size(), 0);
        chk("e0_id_held", 32'(bus.effect_id), 0);

        // Simultaneous req 011 picks effect 1.
        reset_counts();
        start_fx(3'b011, 1);
        wait_note(3, "e1_reach_last");
        chk("e1_first_period", first_gap, 80);

        // Last note of effect 1: final dur_tick together with req 100.
        tick_on = 1'b0;
        step(3'b000, 1'b0);
        k = 0;
        while (note_ticks < 2 && k < 10) begin
            step(3'b000, 1'b1);
            k++;
        end
        chk("e1_last_two_ticks", note_ticks, 2);
        exp_q.delete();
        push_effect(2);
        step(3'b100, 1'b1);
        chk("pre_wins_busy", 32'(bus.busy), 1);
        chk("pre_wins_load", 32'(bus.play_en), 0);
        chk("pre_wins_effect", 32'(bus.effect_id), 2);
        chk("pre_wins_note", 32'(bus.note_idx), 0);
        tick_on = 1'b1;

        // Effect 2 playing: a lower request is dropped.
        wait_note(1, "e2_reach_note1");
        step(3'b001, 1'b0);
        chk("ign_effect", 32'(bus.effect_id), 2);
        chk("ign_note", 32'(bus.note_idx), 1);
        chk("ign_still_play", 32'(bus.play_en), 1);
        wait_idle("e2_done");
        chk("e1e2_notes", notes_played, 8);
        chk("e2_queue_empty", exp_q.size(), 0);
        chk("e2_id_held", 32'(bus.effect_id), 2);

        // Effect 0 preempted by effect 2.
        reset_counts();
        start_fx(3'b001, 0);
        repeat (10) step(3'b000, 1'b0);
        exp_q.delete();
        push_effect(2);
        step(3'b100, 1'b0);
        chk("pre_busy", 32'(bus.busy), 1);
        chk("pre_load", 32'(bus.play_en), 0);
        chk("pre_effect", 32'(bus.effect_id), 2);
        chk("pre_note", 32'(bus.note_idx), 0);
        wait_idle("pre_e2_done");
        chk("pre_first_period", first_gap, 60);
        chk("pre_notes", notes_played, 5);
        chk("pre_queue_empty", exp_q.size(), 0);

        // Asynchronous reset during effect 1 note 2, then restart.
        reset_counts();
        start_fx(3'b010, 1);
        wait_note(2, "e1_reach_note2");
        repeat (5) step(3'b000, 1'b0);
        resetN = 1'b0;
        #1;
        chk("arst_tone_en", 32'(bus.tone_en), 0);
        chk("arst_play_en", 32'(bus.play_en), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_effect_id", 32'(bus.effect_id), 0);
        chk("arst_note_idx", 32'(bus.note_idx), 0);
        exp_q.delete();
        pulses_before = pulses;
        repeat (3) step(3'b000, 1'b0);
        chk("arst_no_pulses", pulses, pulses_before);
        chk("arst_busy_held", 32'(bus.busy), 0);
        resetN = 1'b1;
        reset_counts();
        start_fx(3'b010, 1);
        wait_idle("restart_done");
        chk("restart_notes", notes_played, 4);
        chk("restart_first_period", first_gap, 80);
        chk("restart_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
